booth_ctrl: RTL and testbench



---
 rtl/booth_ctrl.sv | 163 ++++++++++++++++
 tb/tb_booth_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// booth_ctrl: control unit for the radix-2 Booth 8x8 signed multiplier.
// Sequences the A/Q/M datapath with Moore strobes c0..c7 and reads back the
// Booth pair {q0, q_1} in CHECK to choose between ADD, SUB and NOP.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_b  - asynchronous active-low reset
//   start  - begin a multiplication (sampled only in IDLE)
//   q0     - Q[0] from the Q register
//   q_1    - Q[-1], the last bit shifted out of Q
//   c0     - clear A and Q[-1], load M
//   c1     - load Q
//   c2     - write adder result into A
//   c3     - adder mode, 1 = A - M (only high with c2)
//   c4     - arithmetic shift right of {A, Q, Q[-1]}
//   c6     - A drives output bus
//   c7     - Q drives output bus
//   busy   - high from INIT through OUTQ
//   done   - one-cycle pulse in DONE
//
// Build option: define BOOTH_CTRL_SKIP_EN to make CHECK go straight to SHIFT
// for Booth pairs 00/11, skipping the NOP cycle (variable latency).

module booth_ctrl (
    input  logic clk,
    input  logic rst_b,
    input  logic start,
    input  logic q0,
    input  logic q_1,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic c3,
    output logic c4,
    output logic c6,
    output logic c7,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_W = 3;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] INIT  = 4'd1;
    localparam logic [3:0] LOADQ = 4'd2;
    localparam logic [3:0] CHECK = 4'd3;
    localparam logic [3:0] ADD   = 4'd4;
    localparam logic [3:0] SUB   = 4'd5;
    localparam logic [3:0] NOP   = 4'd6;
    localparam logic [3:0] SHIFT = 4'd7;
    localparam logic [3:0] OUTA  = 4'd8;
    localparam logic [3:0] OUTQ  = 4'd9;
    localparam logic [3:0] DONE  = 4'd10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic c0_nxt, c1_nxt, c2_nxt, c3_nxt, c4_nxt, c6_nxt, c7_nxt;
    logic busy_nxt, done_nxt;

    // State, counter and output registers. Outputs are loaded with the decode
    // of the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            cnt   <= '0;
            c0    <= 1'b0;
            c1    <= 1'b0;
            c2    <= 1'b0;
            c3    <= 1'b0;
            c4    <= 1'b0;
            c6    <= 1'b0;
            c7    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            c0    <= c0_nxt;
            c1    <= c1_nxt;
            c2    <= c2_nxt;
            c3    <= c3_nxt;
            c4    <= c4_nxt;
            c6    <= c6_nxt;
            c7    <= c7_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state, iteration counter and Moore output decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        c0_nxt    = 1'b0;
        c1_nxt    = 1'b0;
        c2_nxt    = 1'b0;
        c3_nxt    = 1'b0;
        c4_nxt    = 1'b0;
        c6_nxt    = 1'b0;
        c7_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE:  if (start) state_nxt = INIT;
            INIT: begin
                cnt_nxt   = '0;
                state_nxt = LOADQ;
            end
            LOADQ: state_nxt = CHECK;
            CHECK: begin
                case ({q0, q_1})
                    2'b10:   state_nxt = SUB;
                    2'b01:   state_nxt = ADD;
`ifdef BOOTH_CTRL_SKIP_EN
                    default: state_nxt = SHIFT;
`else
                    default: state_nxt = NOP;
`endif
                endcase
            end
            ADD:   state_nxt = SHIFT;
            SUB:   state_nxt = SHIFT;
            NOP:   state_nxt = SHIFT;
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = OUTA;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    state_nxt = CHECK;
                end
            end
            OUTA:    state_nxt = OUTQ;
            OUTQ:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Strobes belong to the state being entered.
        case (state_nxt)
            INIT:  c0_nxt = 1'b1;
            LOADQ: c1_nxt = 1'b1;
            ADD:   c2_nxt = 1'b1;
            SUB: begin
                c2_nxt = 1'b1;
                c3_nxt = 1'b1;
            end
            SHIFT: c4_nxt = 1'b1;
            OUTA:  c6_nxt = 1'b1;
            OUTQ:  c7_nxt = 1'b1;
            DONE:  done_nxt = 1'b1;
            default: ;
        endcase

        busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: directed self-checking bench for booth_ctrl. The Q register
// is modelled by presenting original multiplier bit i as Q[0] (and bit i-1
// as Q[-1]) in iteration i, which is what the arithmetic shift delivers.

module tb_booth_ctrl;

    logic clk;
    logic rst_b;
    logic start;
    logic q0;
    logic q_1;
    logic c0, c1, c2, c3, c4, c6, c7, busy, done;
    logic [8:0] outs;

    int n_checks;
    int n_fail;

    booth_ctrl dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .q0    (q0),
        .q_1   (q_1),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c6    (c6),
        .c7    (c7),
        .busy  (busy),
        .done  (done)
    );

    assign outs = {c0, c1, c2, c3, c4, c6, c7, busy, done};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Run one multiplication from IDLE; pulse_at > 0 raises start for one
    // cycle at that cycle index (counted from INIT = 1) while busy.
    task automatic run_op(input string name, input logic [7:0] qv,
                          input logic [7:0] exp_mask, input logic [7:0] exp_sub,
                          input int pulse_at);
        int exp_lat;
        int done_cyc, n_done, n_shift, it;
        int c0_cyc, c1_cyc, c6_cyc, c7_cyc, busy_err, excl_err;
        logic [7:0] mask;
        logic [7:0] sub;
`ifdef BOOTH_CTRL_SKIP_EN
        exp_lat = 21 + $countones(exp_mask);
`else
        exp_lat = 29;
`endif
        done_cyc = 0; n_done = 0; n_shift = 0; it = 0;
        c0_cyc = 0; c1_cyc = 0; c6_cyc = 0; c7_cyc = 0;
        busy_err = 0; excl_err = 0;
        mask = '0;
        sub  = '0;
        q0 = 1'b0;
        q_1 = 1'b0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            start = (cyc == pulse_at);
            if (c0) c0_cyc = cyc;
            if (c1) begin
                c1_cyc = cyc;
                it  = 0;
                q0  = qv[0];
                q_1 = 1'b0;
            end
            if (c2 && it < 8) begin
                mask[it] = 1'b1;
                sub[it]  = c3;
            end
            if (c3 && !c2) excl_err++;
            if (c6 && c7) excl_err++;
            if (c6) c6_cyc = cyc;
            if (c7) c7_cyc = cyc;
            if (c4) begin
                n_shift++;
                it++;
                if (it < 8) begin
                    q0  = qv[it];
                    q_1 = qv[it-1];
                end
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
                if (busy) busy_err++;
            end else if (done_cyc == 0 && !busy) begin
                busy_err++;
            end else if (done_cyc != 0 && busy) begin
                busy_err++;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 5) break;
            @(posedge clk); #1;
        end
        start = 1'b0;

        check({name, ".latency"},  32'(done_cyc), 32'(exp_lat));
        check({name, ".n_done"},   32'(n_done), 32'd1);
        check({name, ".n_shift"},  32'(n_shift), 32'd8);
        check({name, ".c2_iters"}, 32'(mask), 32'(exp_mask));
        check({name, ".c3_iters"}, 32'(sub), 32'(exp_sub));
        check({name, ".c0_cyc"},   32'(c0_cyc), 32'd1);
        check({name, ".c1_cyc"},   32'(c1_cyc), 32'd2);
        check({name, ".c6_cyc"},   32'(c6_cyc), 32'(exp_lat - 2));
        check({name, ".c7_cyc"},   32'(c7_cyc), 32'(exp_lat - 1));
        check({name, ".busy"},     32'(busy_err), 32'd0);
        check({name, ".excl"},     32'(excl_err), 32'd0);
    endtask

    initial begin
        int n_shift;
        int lat0;
        int done1, done2, low_cnt, low_first;

        n_checks = 0;
        n_fail   = 0;
        clk   = 1'b0;
        rst_b = 1'b0;
        start = 1'b0;
        q0    = 1'b0;
        q_1   = 1'b0;
`ifdef BOOTH_CTRL_SKIP_EN
        lat0 = 21;
`else
        lat0 = 29;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset.outs", 32'(outs), 32'd0);
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle.outs", 32'(outs), 32'd0);

        // Booth pairs per iteration, hand-derived from the multiplier bits.
        run_op("q00", 8'h00, 8'h00, 8'h00, 0);
        run_op("q01", 8'h01, 8'h03, 8'h01, 0);
        run_op("q55", 8'h55, 8'hFF, 8'h55, 0);
        run_op("qFF", 8'hFF, 8'h01, 8'h01, 0);
        run_op("q80", 8'h80, 8'h80, 8'h80, 0);
        run_op("busy_start", 8'h01, 8'h03, 8'h01, 10);

        // Asynchronous reset during the 4th SHIFT.
        q0 = 1'b0;
        q_1 = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_shift = 0;
        for (int i = 0; i < 60; i++) begin
            if (c4) n_shift++;
            if (n_shift >= 4) break;
            @(posedge clk); #1;
        end
        check("rst.shift4_reached", 32'(n_shift), 32'd4);
        check("rst.in_shift", 32'(c4), 32'd1);
        rst_b = 1'b0;
        #1;
        check("rst.async_outs", 32'(outs), 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst.stays_idle", 32'(outs), 32'd0);
        run_op("after_rst", 8'h01, 8'h03, 8'h01, 0);

        // start held high across two operations.
        q0 = 1'b0;
        q_1 = 1'b0;
        done1 = 0; done2 = 0; low_cnt = 0; low_first = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 2 * lat0 + 1; cyc++) begin
            if (done) begin
                if (done1 == 0) done1 = cyc;
                else if (done2 == 0) done2 = cyc;
            end
            if (!busy && cyc <= 2 * lat0) begin
                low_cnt++;
                if (low_first == 0) low_first = cyc;
            end
            if (cyc == 2 * lat0 + 1) start = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        check("cont.done1", 32'(done1), 32'(lat0));
        check("cont.done2", 32'(done2), 32'(2 * lat0 + 1));
        check("cont.busy_low_cnt", 32'(low_cnt), 32'd2);
        check("cont.busy_low_first", 32'(low_first), 32'(lat0));
        repeat (3) @(posedge clk);
        #1;
        check("cont.idle_end", 32'(outs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
